// File: rtl/hs_delay_pipe.sv
// Chain of STAGES matched-delay handshake slots between a req/ack input port and a req/ack output port.
// Define HS_DELAY_PIPE_TWO_PHASE_EN for 2-phase (transition) signalling on both ports; the default is 4-phase.
module hs_delay_pipe #(
  parameter int STAGES = 2,
  parameter int DELAY  = 25,
  parameter int DATA_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_in_i,
  input  logic [DATA_W-1:0]             data_in_i,
  output logic                          ack_in_o,
  output logic                          req_out_o,
  output logic [DATA_W-1:0]             data_out_o,
  input  logic                          ack_out_i,
  output logic [$clog2(STAGES+1)-1:0]   occupancy_o
);

  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_BUSY, SLOT_FULL} slot_e;
`ifdef HS_DELAY_PIPE_TWO_PHASE_EN
  typedef enum logic {OUT_IDLE, OUT_REQ} out_state_e;
`else
  typedef enum logic {IN_IDLE, IN_ACK} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_e;
`endif

  slot_e             slot_q   [STAGES];
  slot_e             slot_d   [STAGES];
  logic [CNT_W-1:0]  cnt_q    [STAGES];
  logic [CNT_W-1:0]  cnt_d    [STAGES];
  logic [DATA_W-1:0] data_q   [STAGES];
  logic [DATA_W-1:0] data_d   [STAGES];
  logic [DATA_W-1:0] src_data [STAGES];

  logic [STAGES-1:0] hop;   // slot k empties this edge (transfer onward or output release)
  logic [STAGES-1:0] load;  // slot k loads this edge

  logic              ack_in_q,   ack_in_d;
  logic              req_out_q,  req_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [OCC_W-1:0]  occ_q,      occ_d;
  out_state_e        out_q,      out_d;
`ifndef HS_DELAY_PIPE_TWO_PHASE_EN
  in_state_e         in_q,       in_d;
`endif

  logic capture;
  logic free_last;

  // Input port: capture into slot 0 only when it is empty at the start of the cycle.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    capture  = 1'b0;
    ack_in_d = ack_in_q;
`ifdef HS_DELAY_PIPE_TWO_PHASE_EN
    if ((req_in_i != ack_in_q) && (slot_q[0] == SLOT_EMPTY)) begin
      capture  = 1'b1;
      ack_in_d = ~ack_in_q;
    end
`else
    in_d = in_q;
    case (in_q)
      IN_IDLE: if (req_in_i && (slot_q[0] == SLOT_EMPTY)) begin
        capture  = 1'b1;
        ack_in_d = 1'b1;
        in_d     = IN_ACK;
      end
      IN_ACK: if (!req_in_i) begin
        ack_in_d = 1'b0;
        in_d     = IN_IDLE;
      end
      default: in_d = IN_IDLE;
    endcase
`endif
  end

  // Output port: present the last slot, free it once the downstream completes the handshake.
  always_comb begin
    free_last  = 1'b0;
    out_d      = out_q;
    req_out_d  = req_out_q;
    data_out_d = data_out_q;
    case (out_q)
      OUT_IDLE: if (slot_q[LAST] == SLOT_FULL) begin
        data_out_d = data_q[LAST];
`ifdef HS_DELAY_PIPE_TWO_PHASE_EN
        req_out_d  = ~req_out_q;
`else
        req_out_d  = 1'b1;
`endif
        out_d      = OUT_REQ;
      end
`ifdef HS_DELAY_PIPE_TWO_PHASE_EN
      OUT_REQ: if (ack_out_i == req_out_q) begin
        free_last = 1'b1;
        out_d     = OUT_IDLE;
      end
`else
      OUT_REQ: if (ack_out_i) begin
        req_out_d = 1'b0;
        free_last = 1'b1;
        out_d     = OUT_RTZ;
      end
      OUT_RTZ: if (!ack_out_i) out_d = OUT_IDLE;
`endif
      default: out_d = OUT_IDLE;
    endcase
  end

  // Slot chain: all decisions use start-of-cycle state, so a slot freed this edge cannot also load.
  always_comb begin
    hop         = '0;
    load        = '0;
    src_data[0] = data_in_i;
    load[0]     = capture;
    hop[LAST]   = free_last;
    for (int k = 0; k < STAGES - 1; k++) begin
      hop[k]          = (slot_q[k] == SLOT_FULL) && (slot_q[k+1] == SLOT_EMPTY);
      load[k+1]       = hop[k];
      src_data[k+1]   = data_q[k];
    end

    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      slot_d[k] = slot_q[k];
      cnt_d[k]  = cnt_q[k];
      data_d[k] = data_q[k];
      if (hop[k]) begin
        slot_d[k] = SLOT_EMPTY;
      end else if (load[k]) begin
        cnt_d[k]  = CNT_W'(DELAY);
        data_d[k] = src_data[k];
        slot_d[k] = (DELAY > 0) ? SLOT_BUSY : SLOT_FULL;
      end else if (slot_q[k] == SLOT_BUSY) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
        if (cnt_q[k] == CNT_W'(1)) slot_d[k] = SLOT_FULL;
      end
      if (slot_d[k] != SLOT_EMPTY) occ_d = occ_d + OCC_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_in_q   <= 1'b0;
      req_out_q  <= 1'b0;
      data_out_q <= '0;
      occ_q      <= '0;
      out_q      <= OUT_IDLE;
`ifndef HS_DELAY_PIPE_TWO_PHASE_EN
      in_q       <= IN_IDLE;
`endif
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= SLOT_EMPTY;
        cnt_q[k]  <= '0;
      end
    end else begin
      ack_in_q   <= ack_in_d;
      req_out_q  <= req_out_d;
      data_out_q <= data_out_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
`ifndef HS_DELAY_PIPE_TWO_PHASE_EN
      in_q       <= in_d;
`endif
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= slot_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // NOTE: slot data registers carry no reset; a slot's data is only read after a load while its state is non-EMPTY.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
  end

  assign ack_in_o    = ack_in_q;
  assign req_out_o   = req_out_q;
  assign data_out_o  = data_out_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_hs_delay_pipe.sv
// Scoreboard bench for hs_delay_pipe: driver pushes accepted tokens, a negedge monitor pops/compares
// delivered tokens and tracks occupancy as tokens accepted minus tokens released.
module tb_hs_delay_pipe;

  localparam int STAGES = 2;
  localparam int DELAY  = 2;
  localparam int DATA_W = 32;
  localparam int OCC_W  = $clog2(STAGES + 1);
`ifdef HS_DELAY_PIPE_TWO_PHASE_EN
  localparam bit TWO_PHASE = 1'b1;
`else
  localparam bit TWO_PHASE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_in_i;
  logic [DATA_W-1:0] data_in_i;
  logic              ack_in_o;
  logic              req_out_o;
  logic [DATA_W-1:0] data_out_o;
  logic              ack_out_i;
  logic [OCC_W-1:0]  occupancy_o;

  hs_delay_pipe #(.STAGES(STAGES), .DELAY(DELAY), .DATA_W(DATA_W)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_in_i    (req_in_i),
    .data_in_i   (data_in_i),
    .ack_in_o    (ack_in_o),
    .req_out_o   (req_out_o),
    .data_out_o  (data_out_o),
    .ack_out_i   (ack_out_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] exp_q [$];
  bit   hold_ack = 1'b0;
  int   ack_lat  = 0;
  int   wait_cnt = 0;
  int   model_occ = 0;
  bit   outstanding = 1'b0;
  logic p_ack_in = 1'b0, p_req_out = 1'b0, p_ack_out = 1'b0;
  int   cap_cyc = 0, req_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and downstream responder; samples and drives on the falling edge.
  always @(negedge clk) begin : monitor
    logic cap, rel, new_req;
    if (rst_i) begin
      model_occ   = 0;
      outstanding = 1'b0;
      wait_cnt    = 0;
      exp_q.delete();
      ack_out_i   = 1'b0;
      p_ack_in    = 1'b0;
      p_req_out   = 1'b0;
      p_ack_out   = 1'b0;
    end else begin
      cap     = TWO_PHASE ? (ack_in_o != p_ack_in) : (ack_in_o && !p_ack_in);
      rel     = TWO_PHASE ? (outstanding && (p_ack_out == p_req_out)) : (!req_out_o && p_req_out);
      new_req = TWO_PHASE ? (req_out_o != p_req_out) : (req_out_o && !p_req_out);
      if (cap) begin
        model_occ++;
        cap_cyc = cyc;
      end
      if (rel) begin
        model_occ--;
        outstanding = 1'b0;
      end
      check("occupancy", 64'(occupancy_o), 64'(model_occ));
      if (new_req) begin
        req_cyc     = cyc;
        outstanding = 1'b1;
        wait_cnt    = ack_lat;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_token: got 0x%0h expected no token (cycle %0d)", data_out_o, cyc);
        end else begin
          check("data_out", 64'(data_out_o), 64'(exp_q.pop_front()));
        end
      end
      if (TWO_PHASE) begin
        if (outstanding && (ack_out_i != req_out_o) && !hold_ack) begin
          if (wait_cnt == 0) ack_out_i = req_out_o;
          else wait_cnt--;
        end
      end else begin
        if (req_out_o && !ack_out_i && !hold_ack) begin
          if (wait_cnt == 0) ack_out_i = 1'b1;
          else wait_cnt--;
        end else if (!req_out_o && ack_out_i) begin
          ack_out_i = 1'b0;
        end
      end
      p_ack_in  = ack_in_o;
      p_req_out = req_out_o;
      p_ack_out = ack_out_i;
    end
  end

  task automatic start_req(input logic [DATA_W-1:0] d);
    data_in_i = d;
    req_in_i  = TWO_PHASE ? ~req_in_i : 1'b1;
  endtask

  task automatic finish_req(input logic [DATA_W-1:0] d, input int budget);
    int n = 0;
    while ((ack_in_o !== req_in_i) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    if (ack_in_o !== req_in_i) begin
      check("ack_in_timeout", 64'(ack_in_o), 64'(req_in_i));
      return;
    end
    exp_q.push_back(d);
    if (!TWO_PHASE) begin
      req_in_i = 1'b0;
      n = 0;
      while ((ack_in_o !== 1'b0) && (n < budget)) begin
        @(posedge clk); #1;
        n++;
      end
      if (ack_in_o !== 1'b0) check("ack_in_rtz_timeout", 64'(ack_in_o), 64'(0));
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int budget);
    start_req(d);
    finish_req(d, budget);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (((exp_q.size() != 0) || (model_occ != 0)) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_i    = 1'b1;
    req_in_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack_in"},   64'(ack_in_o),    64'(0));
    check({tag, "_req_out"},  64'(req_out_o),   64'(0));
    check({tag, "_data_out"}, 64'(data_out_o),  64'(0));
    check({tag, "_occ"},      64'(occupancy_o), 64'(0));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    rst_i     = 1'b1;
    req_in_i  = 1'b0;
    data_in_i = '0;
    ack_out_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_idle_outputs("reset");

    // Single token through an empty pipe: capture latency and end-to-end latency.
    ack_lat = 1;
    start_req(32'hA5A5_A5A5);
    t0 = cyc;
    finish_req(32'hA5A5_A5A5, 20);
    check("ack_in_latency", 64'(cap_cyc - t0), 64'(1));
    drain(60);
    check("req_out_latency", 64'(req_cyc - cap_cyc), 64'(STAGES * (DELAY + 1)));

    // Downstream stalled: pipe fills to STAGES tokens, then the next request must wait.
    ack_lat  = 0;
    hold_ack = 1'b1;
    send(32'h0000_0001, 40);
    send(32'h0000_0002, 40);
    start_req(32'h0000_0003);
    repeat (15) @(posedge clk);
    #1;
    check("stall_ack_in", 64'(ack_in_o), 64'(TWO_PHASE ? ~req_in_i : 1'b0));
    check("stall_occ", 64'(occupancy_o), 64'(STAGES));
    hold_ack = 1'b0;
    finish_req(32'h0000_0003, 60);
    drain(100);

    // Reset with tokens in flight: everything is dropped and nothing stale is delivered later.
    hold_ack = 1'b1;
    send(32'hDEAD_0004, 40);
    send(32'hDEAD_0005, 40);
    repeat (8) @(posedge clk);
    pulse_reset();
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_idle_outputs("midrst");
    hold_ack = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    send(32'h0000_0006, 20);
    drain(60);

    // Request already pending when reset is released is accepted as a new request.
    pulse_reset();
    start_req(32'h5EED_0007);
    @(posedge clk); #1;
    rst_i = 1'b0;
    finish_req(32'h5EED_0007, 20);
    drain(60);

    // Random traffic with random gaps and downstream acknowledge latency.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack_lat = int'($urandom_range(0, 3));
      send(DATA_W'($urandom), 200);
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
